// File: rtl/mine_pkg.sv
// rtl/mine_pkg.sv - shared constants, state and slot types for the mine scheduler
package mine_pkg;
   localparam int NUM_ROWS  = 3;
   localparam int NUM_COLS  = 4;
   localparam int NUM_MINES = NUM_ROWS * NUM_COLS;
   localparam int PIX_W     = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_OFFER = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef logic [3:0] slot_idx_t;

   localparam slot_idx_t LAST_SLOT = slot_idx_t'(NUM_MINES - 1);

   // With four columns the slot index is simply {row, col}.
   function automatic slot_idx_t slot_of(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction
endpackage

// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - maps a mine's row/column to its top-left screen pixel
module mine_placer
   import mine_pkg::*;
(
   input  logic [1:0]       row,
   input  logic [1:0]       col,
   output logic [PIX_W-1:0] pixel_x,
   output logic [PIX_W-1:0] pixel_y
);
   localparam logic [PIX_W-1:0] X_BASE = 11'h070;
   localparam logic [PIX_W-1:0] X_STEP = 11'h030;
   localparam logic [PIX_W-1:0] Y_BASE = 11'h080;
   localparam logic [PIX_W-1:0] Y_STEP = 11'h060;

   assign pixel_x = X_BASE + X_STEP * PIX_W'(row);
   assign pixel_y = Y_BASE + Y_STEP * PIX_W'(col);
endmodule

// File: rtl/mine_scheduler.sv
// rtl/mine_scheduler.sv - scans the 3x4 mine grid each frame and offers armed mines
module mine_scheduler
   import mine_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_of_frame,
   input  logic             restart,
   input  logic             hit,
   input  logic [1:0]       hit_row,
   input  logic [1:0]       hit_col,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       mine_row,
   output logic [1:0]       mine_col,
   output logic [PIX_W-1:0] pixel_x,
   output logic [PIX_W-1:0] pixel_y,
   output logic             frame_done,
   output logic [3:0]       alive_count,
   output logic             all_cleared
);
   state_t                 state;
   slot_idx_t              idx;
   logic [NUM_MINES-1:0]   alive;
   logic                   hit_ok;
   slot_idx_t              hit_slot;

   assign hit_ok   = hit && (hit_row != 2'd3);
   assign hit_slot = slot_of(hit_row, hit_col);

   // Count only drops when a live mine dies, so repeated hits are harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive       <= '1;
         alive_count <= 4'(NUM_MINES);
      end else if (restart) begin
         alive       <= '1;
         alive_count <= 4'(NUM_MINES);
      end else if (hit_ok && alive[hit_slot]) begin
         alive[hit_slot] <= 1'b0;
         alive_count     <= alive_count - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         idx      <= '0;
         mine_row <= '0;
         mine_col <= '0;
      end else if (restart) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_of_frame) begin
                  idx   <= '0;
                  state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (alive[idx]) begin
                  mine_row <= idx[3:2];
                  mine_col <= idx[1:0];
                  state    <= ST_OFFER;
               end else if (idx == LAST_SLOT) begin
                  state <= ST_DONE;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            ST_OFFER: begin
               if (out_ready) begin
                  if (idx == LAST_SLOT) begin
                     state <= ST_DONE;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= ST_SCAN;
                  end
               end
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid   = (state == ST_OFFER);
   assign frame_done  = (state == ST_DONE);
   assign all_cleared = (alive_count == 4'd0);

   mine_placer u_placer (
      .row     (mine_row),
      .col     (mine_col),
      .pixel_x (pixel_x),
      .pixel_y (pixel_y)
   );
endmodule

// File: tb/tb_mine_scheduler.sv
// tb/tb_mine_scheduler.sv - directed self-checking bench for mine_scheduler
module tb_mine_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_of_frame, restart, hit, out_ready;
   logic [1:0]  hit_row, hit_col;
   logic        out_valid, frame_done, all_cleared;
   logic [1:0]  mine_row, mine_col;
   logic [10:0] pixel_x, pixel_y;
   logic [3:0]  alive_count;

   int tests  = 0;
   int failed = 0;

   logic [1:0]  o_row [0:15];
   logic [1:0]  o_col [0:15];
   logic [10:0] o_px  [0:15];
   logic [10:0] o_py  [0:15];
   int          n_off, n_valid, done_c;

   logic [10:0] px_tab [0:2];
   logic [10:0] py_tab [0:3];

   always #5 clk = ~clk;

   mine_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_of_frame (start_of_frame),
      .restart        (restart),
      .hit            (hit),
      .hit_row        (hit_row),
      .hit_col        (hit_col),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .mine_row       (mine_row),
      .mine_col       (mine_col),
      .pixel_x        (pixel_x),
      .pixel_y        (pixel_y),
      .frame_done     (frame_done),
      .alive_count    (alive_count),
      .all_cleared    (all_cleared)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_hit(input logic [1:0] r, input logic [1:0] c);
      hit = 1'b1; hit_row = r; hit_col = c;
      tick();
      hit = 1'b0;
   endtask

   // c counts edges since the cycle start_of_frame was high.
   task automatic run_frame();
      n_off = 0; n_valid = 0; done_c = -1;
      start_of_frame = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         start_of_frame = 1'b0;
         if (out_valid) n_valid++;
         if (out_valid && out_ready && n_off < 16) begin
            o_row[n_off] = mine_row; o_col[n_off] = mine_col;
            o_px[n_off]  = pixel_x;  o_py[n_off]  = pixel_y;
            n_off++;
         end
         if (frame_done) begin
            done_c = c;
            break;
         end
      end
   endtask

   // Compares recorded offers against the row-major list of slots not in dead_mask.
   task automatic chk_offers(input string tag, input logic [11:0] dead_mask);
      int k;
      k = 0;
      for (int s = 0; s < 12; s++) begin
         if (!dead_mask[s] && k < n_off) begin
            chk({tag, "_row"}, 32'(o_row[k]), 32'(s / 4));
            chk({tag, "_col"}, 32'(o_col[k]), 32'(s % 4));
            chk({tag, "_px"},  32'(o_px[k]),  32'(px_tab[s / 4]));
            chk({tag, "_py"},  32'(o_py[k]),  32'(py_tab[s % 4]));
            k++;
         end
      end
   endtask

   initial begin
      logic [1:0]  s_row, s_col;
      logic [10:0] s_px, s_py;
      int          cnt_fd, cnt_ov;
      bit          found;

      px_tab[0] = 11'h070; px_tab[1] = 11'h0A0; px_tab[2] = 11'h0D0;
      py_tab[0] = 11'h080; py_tab[1] = 11'h0E0; py_tab[2] = 11'h140; py_tab[3] = 11'h1A0;

      rst_n = 1'b0; start_of_frame = 1'b0; restart = 1'b0; hit = 1'b0;
      hit_row = 2'd0; hit_col = 2'd0; out_ready = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_out_valid",   32'(out_valid),   32'd0);
      chk("rst_frame_done",  32'(frame_done),  32'd0);
      chk("rst_alive_count", 32'(alive_count), 32'd12);
      chk("rst_all_cleared", 32'(all_cleared), 32'd0);
      chk("rst_mine_row",    32'(mine_row),    32'd0);
      chk("rst_mine_col",    32'(mine_col),    32'd0);
      chk("rst_pixel_x",     32'(pixel_x),     32'h070);
      chk("rst_pixel_y",     32'(pixel_y),     32'h080);
      rst_n = 1'b1;
      tick();

      // Full frame, consumer always ready
      out_ready = 1'b1;
      run_frame();
      chk("full_offers", 32'(n_off), 32'd12);
      chk("full_done_c", 32'(done_c), 32'd25);
      chk_offers("full", 12'h000);
      chk("full_first_px", 32'(o_px[0]), 32'h070);
      chk("full_first_py", 32'(o_py[0]), 32'h080);
      chk("full_12_px",    32'(o_px[6]), 32'h0A0);
      chk("full_12_py",    32'(o_py[6]), 32'h140);
      chk("full_last_px",  32'(o_px[11]), 32'h0D0);
      chk("full_last_py",  32'(o_py[11]), 32'h1A0);
      tick();
      chk("full_done_one_cycle", 32'(frame_done), 32'd0);

      // Backpressure on the first offer
      out_ready = 1'b0;
      start_of_frame = 1'b1;
      tick();
      start_of_frame = 1'b0;
      tick();
      chk("stall_latency_valid", 32'(out_valid), 32'd1);
      s_row = mine_row; s_col = mine_col; s_px = pixel_x; s_py = pixel_y;
      chk("stall_row0", 32'(s_row), 32'd0);
      chk("stall_col0", 32'(s_col), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_row",   32'(mine_row),  32'd0);
         chk("stall_col",   32'(mine_col),  32'd0);
         chk("stall_px",    32'(pixel_x),   32'h070);
         chk("stall_py",    32'(pixel_y),   32'h080);
      end
      out_ready = 1'b1;
      tick();
      chk("stall_release_gap", 32'(out_valid), 32'd0);
      tick();
      chk("stall_next_valid", 32'(out_valid), 32'd1);
      chk("stall_next_col",   32'(mine_col),  32'd1);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (frame_done) begin found = 1'b1; break; end
         tick();
      end
      chk("stall_frame_done", 32'(found), 32'd1);
      tick();

      // Hit (1,1): slot 5 skipped
      do_hit(2'd1, 2'd1);
      chk("hit11_alive", 32'(alive_count), 32'd11);
      run_frame();
      chk("hit11_offers", 32'(n_off), 32'd11);
      chk("hit11_done_c", 32'(done_c), 32'd23 + 32'd1);
      chk_offers("hit11", 12'h020);
      tick();

      // Ignored hit row 3 and repeat hit on a dead slot
      do_hit(2'd3, 2'd1);
      chk("hit_row3_alive", 32'(alive_count), 32'd11);
      do_hit(2'd1, 2'd1);
      chk("hit_dead_alive", 32'(alive_count), 32'd11);

      // Restart during the offer of (2,0)
      found = 1'b0;
      start_of_frame = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         start_of_frame = 1'b0;
         if (out_valid && mine_row == 2'd2 && mine_col == 2'd0) begin found = 1'b1; break; end
      end
      chk("rs_reached_20", 32'(found), 32'd1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("rs_out_valid",  32'(out_valid),   32'd0);
      chk("rs_frame_done", 32'(frame_done),  32'd0);
      chk("rs_alive",      32'(alive_count), 32'd12);
      cnt_fd = 0; cnt_ov = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (frame_done) cnt_fd++;
         if (out_valid) cnt_ov++;
      end
      chk("rs_no_frame_done", 32'(cnt_fd), 32'd0);
      chk("rs_no_valid",      32'(cnt_ov), 32'd0);
      run_frame();
      chk("rs_after_offers", 32'(n_off), 32'd12);
      chk("rs_after_done_c", 32'(done_c), 32'd25);
      tick();

      // Clear every mine
      for (int s = 0; s < 12; s++) do_hit(2'(s / 4), 2'(s % 4));
      chk("clr_alive",       32'(alive_count), 32'd0);
      chk("clr_all_cleared", 32'(all_cleared), 32'd1);
      run_frame();
      chk("clr_offers",  32'(n_off),   32'd0);
      chk("clr_valids",  32'(n_valid), 32'd0);
      chk("clr_done_c",  32'(done_c),  32'd13);
      tick();

      // Restart and hit together: restart wins
      restart = 1'b1; hit = 1'b1; hit_row = 2'd0; hit_col = 2'd0;
      tick();
      restart = 1'b0; hit = 1'b0;
      chk("rh_alive",       32'(alive_count), 32'd12);
      chk("rh_all_cleared", 32'(all_cleared), 32'd0);

      // Reset mid-scan
      start_of_frame = 1'b1;
      tick();
      start_of_frame = 1'b0;
      tick();
      chk("mr_pre_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_async_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt_fd = 0; cnt_ov = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (frame_done) cnt_fd++;
         if (out_valid) cnt_ov++;
      end
      chk("mr_no_frame_done", 32'(cnt_fd), 32'd0);
      chk("mr_no_valid",      32'(cnt_ov), 32'd0);
      chk("mr_alive",         32'(alive_count), 32'd12);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/mine_scheduler.md
MINE_SCHEDULER -- requirements
Module: mine_scheduler

Interface
REQ-001 The block SHALL use one clock and asynchronous active-low reset, with these ports (clock and reset first):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active low
- start_of_frame  in  1  single-cycle pulse; begin one scan of the mine grid
- restart  in  1  single-cycle pulse; re-arm all mines, abort any scan in progress
- hit  in  1  single-cycle pulse; disarm the mine at hit_row/hit_col
- hit_row  in  2  row of the hit mine (0..2 valid)
- hit_col  in  2  column of the hit mine (0..3 valid)
- out_valid  out  1  mine_row/mine_col/pixel_x/pixel_y hold an armed mine for the consumer
- out_ready  in  1  consumer accepts the offered mine
- mine_row  out  2  row of the offered mine
- mine_col  out  2  column of the offered mine
- pixel_x  out  11  top-left x of the offered mine
- pixel_y  out  11  top-left y of the offered mine
- frame_done  out  1  single-cycle pulse; scan finished
- alive_count  out  4  number of armed mines, 0..12
- all_cleared  out  1  high when alive_count == 0

Function
REQ-002 The grid SHALL be 3 rows x 4 columns (12 slots), slot index = row*4 + col, with one alive bit per slot.
REQ-003 Placement SHALL be pixel_x = 0x70 + 0x30*row and pixel_y = 0x80 + 0x60*col, in 11-bit unsigned arithmetic, computed from the registered mine_row/mine_col.
REQ-004 The FSM SHALL have the states IDLE, SCAN, OFFER and DONE.
REQ-005 In IDLE, start_of_frame SHALL set the index to 0 and move to SCAN; start_of_frame SHALL be ignored in every other state.
REQ-006 In SCAN, the FSM SHALL spend one cycle per slot:
- alive slot: latch its row/col and move to OFFER
- dead slot: advance the index
- dead slot at index 11: move to DONE
REQ-007 In OFFER, out_valid SHALL be 1 and the outputs mine_row, mine_col, pixel_x and pixel_y SHALL stay stable until out_ready is sampled high.
REQ-008 When out_valid and out_ready are both high, the FSM SHALL:
- at index 11: move to DONE
- otherwise: increment the index and return to SCAN
REQ-009 Latency SHALL be as follows:
- start_of_frame high at cycle t with slot 0 alive: out_valid high at cycle t+2
- a full scan with no armed mines: frame_done at cycle t+13
REQ-010 DONE SHALL last exactly one cycle, assert frame_done for that cycle, and then return to IDLE.
REQ-011 hit with hit_row <= 2 SHALL clear the addressed alive bit on the next edge; hit with hit_row == 3 SHALL be ignored.
REQ-012 A hit on the slot currently in OFFER SHALL clear its alive bit while the offer stays valid until the handshake completes.
REQ-013 A hit on a slot not yet scanned in the current frame SHALL cause that slot to be skipped.
REQ-014 restart SHALL set all 12 alive bits and force IDLE on the next edge; out_valid SHALL drop on that edge and frame_done SHALL NOT pulse.
REQ-015 If restart and hit occur in the same cycle, restart SHALL win and all 12 mines SHALL be armed.
REQ-016 alive_count SHALL be a registered count that is updated on the same edge as the alive bits.
REQ-017 all_cleared SHALL be a combinational function of alive_count.
REQ-018 A hit on an already-dead slot SHALL leave alive_count unchanged.

Reset
REQ-019 On rst_n low, the block SHALL asynchronously:
- set the FSM to IDLE and the index to 0
- set all 12 alive bits
- set alive_count to 12
- drive out_valid, frame_done, all_cleared, mine_row and mine_col to 0
REQ-020 While mine_row and mine_col are 0 in reset, pixel_x SHALL read 0x070 and pixel_y SHALL read 0x080.
REQ-021 Reset asserted mid-scan SHALL abandon the scan with no frame_done pulse.

Structure
REQ-022 The shared package mine_pkg SHALL hold:
- constants NUM_ROWS=3, NUM_COLS=4, NUM_MINES=12
- the FSM state enum
- the slot-index typedef
REQ-023 The block SHALL instantiate exactly one mine_placer sub-module, driven by the registered mine_row/mine_col, to produce pixel_x and pixel_y.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then start_of_frame with out_ready tied high -> 12 offers in row-major order; first offer is (0,0) at 0x070/0x080; offer (1,2) is 0x0A0/0x140; last offer is (2,3) at 0x0D0/0x1A0; then one frame_done pulse.
- Hit (1,1), then start_of_frame -> 11 offers with slot 5 skipped; alive_count=11.
- out_ready held low for 5 cycles during offer (0,0) -> out_valid and all payload stable for 5 cycles; the scan then advances.
- 12 distinct hits, then start_of_frame -> all_cleared=1, no out_valid, frame_done 13 cycles after start.
- restart during OFFER of (2,0) -> out_valid low next cycle, no frame_done, alive_count=12; start_of_frame is accepted afterward.
- Hit with hit_row=3, and a second hit on a dead slot -> alive_count unchanged.
